// File: rtl/mant_mult_pkg.sv
// Shared types and constants for the sequential mantissa multiplier.
package mant_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MANT_W_DEFAULT = 24;

  // Step counter must count 0..W, so it needs clog2(W+1) bits.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mant_mult_step.sv
// One radix-2 shift-add step: the sequential equivalent of a single
// array-multiplier row.
module mant_mult_step
  import mant_mult_pkg::*;
#(
  parameter int W = MANT_W_DEFAULT
) (
  input  logic [W:0]   acc,
  input  logic [W-1:0] q,
  input  logic [W-1:0] m,
  output logic [W:0]   acc_next,
  output logic [W-1:0] q_next
);

  logic [W:0] sum;

  // acc is one bit wider than m, so the add cannot overflow.
  always_comb begin
    sum      = acc + (q[0] ? {1'b0, m} : '0);
    acc_next = {1'b0, sum[W:1]};
    q_next   = {sum[0], q[W-1:1]};
  end

endmodule

// File: rtl/mant_mult_seq.sv
// Sequential W x W -> 2W unsigned mantissa multiplier, one multiplier bit per cycle.
// Optional MANT_MULT_ZERO_SKIP_EN: a zero operand jumps straight to DONE with product 0.
//
// state | meaning
// IDLE  | waiting for an operand pair; in_ready high
// BUSY  | running the W shift-add steps
// DONE  | product valid, held until out_ready
module mant_mult_seq
  import mant_mult_pkg::*;
#(
  parameter int W = MANT_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int             CW   = cnt_width(W);
  localparam logic [CW-1:0]  LAST = CW'(W - 1);

  state_t        state;
  logic [W:0]    acc;
  logic [W-1:0]  q;
  logic [W-1:0]  m;
  logic [CW-1:0] cnt;
  logic [W:0]    acc_nx;
  logic [W-1:0]  q_nx;
  logic          accept;
  logic          zero_op;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

`ifdef MANT_MULT_ZERO_SKIP_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  mant_mult_step #(.W(W)) u_step (
    .acc      (acc),
    .q        (q),
    .m        (m),
    .acc_next (acc_nx),
    .q_next   (q_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      q         <= '0;
      m         <= '0;
      cnt       <= '0;
      product   <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            m   <= a;
            q   <= b;
            acc <= '0;
            cnt <= '0;
            if (zero_op) begin
              product   <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc <= acc_nx;
          q   <= q_nx;
          cnt <= cnt + 1'b1;
          // The final step's result goes straight into the product register.
          if (cnt == LAST) begin
            product   <= {acc_nx[W-1:0], q_nx};
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mant_mult_seq.sv
// Bench for mant_mult_seq: W=24 directed scenarios plus W=8 / W=53 random sweeps
// against a plain multiply reference.
module tb_mant_mult_seq;

`ifdef MANT_MULT_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        iv24 = 0, ir24, ov24, or24 = 0, busy24;
  logic [23:0] a24 = 0, b24 = 0;
  logic [47:0] p24;

  logic        iv8 = 0, ir8, ov8, or8 = 0, busy8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] p8;

  logic         iv53 = 0, ir53, ov53, or53 = 0, busy53;
  logic [52:0]  a53 = 0, b53 = 0;
  logic [105:0] p53;

  mant_mult_seq #(.W(24)) dut24 (
    .clk(clk), .rst(rst), .in_valid(iv24), .in_ready(ir24), .a(a24), .b(b24),
    .out_valid(ov24), .out_ready(or24), .product(p24), .busy(busy24));

  mant_mult_seq #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8));

  mant_mult_seq #(.W(53)) dut53 (
    .clk(clk), .rst(rst), .in_valid(iv53), .in_ready(ir53), .a(a53), .b(b53),
    .out_valid(ov53), .out_ready(or53), .product(p53), .busy(busy53));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one W=24 operation; reports cycles from accept edge to out_valid.
  task automatic run24(input logic [23:0] aa, input logic [23:0] bb,
                       output int lat, output logic busy_first,
                       output logic [47:0] prod, output bit ok);
    int t;
    iv24 = 1'b1; a24 = aa; b24 = bb;
    t = 0;
    while (!ir24 && t < 200) begin tick(); t++; end
    tick();
    iv24 = 1'b0;
    busy_first = busy24;
    lat = 0;
    while (!ov24 && lat < 200) begin tick(); lat++; end
    ok   = ov24;
    prod = p24;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_tests++; if (ir24 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", ir24); end
    n_tests++; if (ov24 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", ov24); end
    n_tests++; if (busy24 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy24); end
    n_tests++; if (p24 !== 48'h0) begin n_fail++; $display("FAIL reset_product: got %h expected 0", p24); end
    tick(); tick();
    rst = 1'b0;
    #1;
    n_tests++; if (ir24 !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", ir24); end
  endtask

  task automatic test_corners();
    logic [23:0] ca [4];
    logic [23:0] cb [4];
    int lat, exp_lat;
    logic bf, exp_bf;
    logic [47:0] prod, exp_p;
    bit ok;
    ca = '{24'hFFFFFF, 24'h800000, 24'hC00000, 24'h000000};
    cb = '{24'hFFFFFF, 24'h800000, 24'hA00000, 24'h123456};
    or24 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_p   = 48'(64'(ca[i]) * 64'(cb[i]));
      exp_lat = (ZS && (ca[i] == 0 || cb[i] == 0)) ? 0 : 24;
      exp_bf  = (exp_lat != 0);
      run24(ca[i], cb[i], lat, bf, prod, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL corner%0d_timeout: out_valid never rose", i); end
      n_tests++; if (prod !== exp_p) begin n_fail++; $display("FAIL corner%0d_product: got %h expected %h", i, prod, exp_p); end
      n_tests++; if (lat != exp_lat) begin n_fail++; $display("FAIL corner%0d_latency: got %0d expected %0d", i, lat, exp_lat); end
      n_tests++; if (bf !== exp_bf) begin n_fail++; $display("FAIL corner%0d_busy: got %b expected %b", i, bf, exp_bf); end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lat, t;
    logic bf;
    logic [47:0] prod;
    bit ok;
    or24 = 1'b0;
    run24(24'hC00000, 24'hA00000, lat, bf, prod, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: out_valid never rose"); end
    iv24 = 1'b1; a24 = 24'd3; b24 = 24'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++; if (ov24 !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: cycle %0d got %b expected 1", i, ov24); end
      n_tests++; if (p24 !== 48'h780000000000) begin n_fail++; $display("FAIL bp_hold_product: cycle %0d got %h expected 780000000000", i, p24); end
      n_tests++; if (ir24 !== 1'b0) begin n_fail++; $display("FAIL bp_hold_in_ready: cycle %0d got %b expected 0", i, ir24); end
    end
    or24 = 1'b1;
    tick();
    or24 = 1'b0;
    n_tests++; if (ov24 !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", ov24); end
    n_tests++; if (ir24 !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b expected 1", ir24); end
    tick();
    iv24 = 1'b0;
    n_tests++; if (busy24 !== 1'b1) begin n_fail++; $display("FAIL bp_new_accept: busy got %b expected 1", busy24); end
    t = 0;
    while (!ov24 && t < 200) begin tick(); t++; end
    n_tests++; if (p24 !== 48'd21) begin n_fail++; $display("FAIL bp_new_product: got %h expected 15", p24); end
    or24 = 1'b1;
    tick();
  endtask

  task automatic test_reset_abort();
    int lat;
    logic bf;
    logic [47:0] prod;
    bit ok, seen;
    int t;
    or24 = 1'b1;
    iv24 = 1'b1; a24 = 24'hFFFFFF; b24 = 24'hFFFFFF;
    t = 0;
    while (!ir24 && t < 200) begin tick(); t++; end
    tick();
    iv24 = 1'b0;
    repeat (12) tick();
    #2 rst = 1'b1;
    #1;
    n_tests++; if (busy24 !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy24); end
    n_tests++; if (ov24 !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b expected 0", ov24); end
    n_tests++; if (p24 !== 48'h0) begin n_fail++; $display("FAIL abort_product: got %h expected 0", p24); end
    n_tests++; if (ir24 !== 1'b0) begin n_fail++; $display("FAIL abort_in_ready: got %b expected 0", ir24); end
    tick();
    rst = 1'b0;
    #1;
    n_tests++; if (ir24 !== 1'b1) begin n_fail++; $display("FAIL abort_release_in_ready: got %b expected 1", ir24); end
    seen = 1'b0;
    repeat (30) begin tick(); if (ov24) seen = 1'b1; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid: got %b expected 0", seen); end
    run24(24'd3, 24'd5, lat, bf, prod, ok);
    n_tests++; if (!ok || prod !== 48'd15) begin n_fail++; $display("FAIL abort_next_op: got %h ok=%b expected 15", prod, ok); end
    n_tests++; if (lat != 24) begin n_fail++; $display("FAIL abort_next_latency: got %0d expected 24", lat); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [23:0] ra, rb;
    logic [47:0] exp_p;
    int rise [3];
    int nr, cyc;
    logic prev;
    ra = 24'($urandom_range(1, 24'hFFFFFF));
    rb = 24'($urandom_range(1, 24'hFFFFFF));
    exp_p = 48'(64'(ra) * 64'(rb));
    or24 = 1'b1;
    iv24 = 1'b1; a24 = ra; b24 = rb;
    nr = 0; cyc = 0; prev = ov24;
    while (nr < 3 && cyc < 200) begin
      tick(); cyc++;
      if (ov24 && !prev) begin
        rise[nr] = cyc;
        nr++;
        n_tests++; if (p24 !== exp_p) begin n_fail++; $display("FAIL b2b_product: got %h expected %h", p24, exp_p); end
      end
      prev = ov24;
    end
    iv24 = 1'b0;
    n_tests++;
    if (nr != 3) begin
      n_fail++; $display("FAIL b2b_timeout: got %0d products expected 3", nr);
    end else begin
      if (rise[1] - rise[0] != 26 || rise[2] - rise[1] != 26) begin
        n_fail++; $display("FAIL b2b_period: got %0d,%0d expected 26", rise[1] - rise[0], rise[2] - rise[1]);
      end
    end
    tick(); tick();
  endtask

  task automatic test_sweep8(input int n);
    logic [15:0] exp_p;
    int t;
    for (int i = 0; i < n; i++) begin
      a8 = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      b8 = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      exp_p = 16'(a8) * 16'(b8);
      iv8 = 1'b1;
      t = 0;
      while (!ir8 && t < 100) begin tick(); t++; end
      tick();
      iv8 = 1'b0;
      t = 0;
      while (!ov8 && t < 100) begin tick(); t++; end
      n_tests++;
      if (!ov8) begin
        n_fail++; $display("FAIL sweep8_timeout: pair %0d", i);
      end else begin
        repeat ($urandom_range(0, 3)) tick();
        if (p8 !== exp_p) begin n_fail++; $display("FAIL sweep8_product: a=%h b=%h got %h expected %h", a8, b8, p8, exp_p); end
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
      end
    end
  endtask

  task automatic test_sweep53(input int n);
    logic [105:0] exp_p;
    int t;
    for (int i = 0; i < n; i++) begin
      a53 = ($urandom_range(0, 31) == 0) ? 53'd0 : 53'({$urandom, $urandom});
      b53 = ($urandom_range(0, 31) == 0) ? 53'd0 : 53'({$urandom, $urandom});
      exp_p = 106'(a53) * 106'(b53);
      iv53 = 1'b1;
      t = 0;
      while (!ir53 && t < 200) begin tick(); t++; end
      tick();
      iv53 = 1'b0;
      t = 0;
      while (!ov53 && t < 200) begin tick(); t++; end
      n_tests++;
      if (!ov53) begin
        n_fail++; $display("FAIL sweep53_timeout: pair %0d", i);
      end else begin
        repeat ($urandom_range(0, 3)) tick();
        if (p53 !== exp_p) begin n_fail++; $display("FAIL sweep53_product: a=%h b=%h got %h expected %h", a53, b53, p53, exp_p); end
        or53 = 1'b1;
        tick();
        or53 = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    fork
      test_sweep8(1000);
      test_sweep53(500);
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
